// File: rtl/os2ip_stream.sv
// OS2IP: assembles a big-endian octet stream into a right-aligned K_BYTES*8-bit integer.
// Streams longer than K_BYTES octets keep the first K_BYTES octets and raise err.
module os2ip_stream #(
  parameter int unsigned K_BYTES = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [8*K_BYTES-1:0]   x,
  output logic                   x_valid,
  input  logic                   x_ready,
  output logic [CNT_W-1:0]       x_len,
  output logic                   err
);

  localparam int unsigned X_W = 8 * K_BYTES;
  localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(K_BYTES);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   release_x;

  // Next-state decode; DRAIN swallows octets beyond K_BYTES until s_last.
  always_comb begin
    state_nxt = state;
    accept    = s_valid & s_ready;
    release_x = x_valid & x_ready;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (s_last) begin
            state_nxt = DONE;
          end else if ((x_len + CNT_W'(1)) == LEN_FULL) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (release_x) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake flags follow the next state so s_ready drops on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= '0;
      x_len   <= '0;
      err     <= 1'b0;
      x_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      s_ready <= (state_nxt != DONE);
      x_valid <= (state_nxt == DONE);
      case (state)
        ACCUM: begin
          if (accept) begin
            x     <= {x[X_W-9:0], s_data};
            x_len <= x_len + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (accept) begin
            err <= 1'b1;
          end
        end
        DONE: begin
          if (release_x) begin
            x     <= '0;
            x_len <= '0;
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
